board_reset_seq: RTL

//  Board-level reset/button front end between PLL and user logic, replacing the fixed 3-flop btn reset sync.

---
 rtl/board_reset_seq_pkg.sv | 21 ++
 rtl/board_reset_seq_if.sv | 37 +++
 rtl/board_reset_seq_btn_debounce.sv | 70 +++++++
 rtl/board_reset_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/board_reset_seq_pkg.sv
// Shared definitions for the board reset sequencer: FSM state encodings
// (also shown on the debug LEDs) and a counter-width helper.
package board_reset_seq_pkg;

  localparam int STATE_W = 2;

  // Encodings are visible on state_dbg, so keep them stable for the LED decode.
  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // Width of a counter that runs 0..v-1 and is always cleared at its
  // terminal count, so it never has to hold v itself. Minimum of one bit.
  function automatic int cnt_w(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/board_reset_seq_if.sv
// Board-facing signal bundle of the reset sequencer. The master side is the
// sequencer itself (consumes PLL lock and buttons, produces resets and
// debounced buttons); the slave side is the board/user logic.
interface board_reset_seq_if #(
  parameter int N_BTN     = 2,
  parameter int N_RST_OUT = 3
);

  logic                                    locked;
  logic [N_BTN-1:0]                        btn_raw;
  logic [N_BTN-1:0]                        btn_db;
  logic [N_BTN-1:0]                        btn_press;
  logic [N_RST_OUT-1:0]                    rst_out;
  logic                                    ready;
  logic [board_reset_seq_pkg::STATE_W-1:0] state_dbg;

  modport master (
    input  locked,
    input  btn_raw,
    output btn_db,
    output btn_press,
    output rst_out,
    output ready,
    output state_dbg
  );

  modport slave (
    output locked,
    output btn_raw,
    input  btn_db,
    input  btn_press,
    input  rst_out,
    input  ready,
    input  state_dbg
  );

endinterface

// File: rtl/board_reset_seq_btn_debounce.sv
// One button channel: synchroniser chain, stability counter and a one-cycle
// press pulse. A change on the synchronised input only reaches btn_db after
// DEBOUNCE_CYCLES consecutive edges of disagreement; shorter glitches vanish.
module board_reset_seq_btn_debounce
  import board_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_press
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   btn_s;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   btn_db_q;
  logic                   btn_db_d;
  logic                   btn_press_q;
  logic                   btn_press_d;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Shift the raw button into the synchroniser; nothing combinational in front of it.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  // Count consecutive disagreeing edges and commit the new level at the terminal count.
  always_comb begin
    cnt_d       = cnt_q;
    btn_db_d    = btn_db_q;
    btn_press_d = 1'b0;
    if (btn_s == btn_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_db_d = btn_s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    btn_press_d = btn_db_d & ~btn_db_q;
  end

  // State registers for the synchroniser, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      btn_db_q    <= 1'b0;
      btn_press_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      btn_db_q    <= btn_db_d;
      btn_press_q <= btn_press_d;
    end
  end

  assign btn_db    = btn_db_q;
  assign btn_press = btn_press_q;

endmodule

// File: rtl/board_reset_seq.sv
// Board-level reset front end sitting between the PLL and user logic.
// Waits for a synchronised PLL lock, holds everything in reset for a settle
// time, then releases the staged resets one by one in ascending order and
// finally raises ready. Losing lock or pressing the reset button drops the
// whole system back into reset on the next edge, all stages at once.
module board_reset_seq
  import board_reset_seq_pkg::*;
#(
  parameter int N_BTN            = 2,
  parameter int SYNC_STAGES      = 3,
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int LOCK_HOLD_CYCLES = 1024,
  parameter int N_RST_OUT        = 3,
  parameter int STAGE_GAP_CYCLES = 16,
  parameter int RST_BTN_IDX      = 0
) (
  input  logic                      CLOCK_50,
  input  logic                      rst,
  board_reset_seq_if.master         bus
);

  localparam int HOLD_W = cnt_w(LOCK_HOLD_CYCLES);
  localparam int GAP_W  = cnt_w(STAGE_GAP_CYCLES);
  localparam int IDX_W  = cnt_w(N_RST_OUT);

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_d;
  logic                   lock_s;

  logic [N_BTN-1:0]       btn_raw_w;
  logic [N_BTN-1:0]       btn_db_w;
  logic [N_BTN-1:0]       btn_press_w;
  logic                   rst_req;

  state_e                 state_q;
  state_e                 state_d;
  logic [HOLD_W-1:0]      hold_cnt_q;
  logic [HOLD_W-1:0]      hold_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q;
  logic [GAP_W-1:0]       gap_cnt_d;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       idx_d;
  logic [N_RST_OUT-1:0]   rst_out_q;
  logic [N_RST_OUT-1:0]   rst_out_d;
  logic                   ready_q;
  logic                   ready_d;

  assign btn_raw_w = bus.btn_raw;

  // One debouncer per button; each owns its own synchroniser chain.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    board_reset_seq_btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk       (CLOCK_50),
      .rst       (rst),
      .btn_raw   (btn_raw_w[i]),
      .btn_db    (btn_db_w[i]),
      .btn_press (btn_press_w[i])
    );
  end

  // PLL lock is asynchronous to CLOCK_50, so it goes through a plain shift register first.
  always_comb begin
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], bus.locked};
  end

  // Lock synchroniser register.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= lock_sync_d;
    end
  end

  assign lock_s  = lock_sync_q[SYNC_STAGES-1];
  assign rst_req = ~lock_s | btn_db_w[RST_BTN_IDX];

  // Next-state logic: a reset request overrides everything, otherwise walk
  // WAIT_LOCK -> HOLD -> RELEASE -> RUN, dropping one reset stage per gap.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out_q;
    ready_d    = ready_q;

    if (rst_req) begin
      state_d    = ST_WAIT_LOCK;
      hold_cnt_d = '0;
      gap_cnt_d  = '0;
      idx_d      = '0;
      rst_out_d  = '1;
      ready_d    = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end

        ST_HOLD: begin
          if (hold_cnt_q == HOLD_W'(LOCK_HOLD_CYCLES - 1)) begin
            hold_cnt_d   = '0;
            gap_cnt_d    = '0;
            idx_d        = IDX_W'(1);
            rst_out_d[0] = 1'b0;
            if (N_RST_OUT == 1) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (gap_cnt_q == GAP_W'(STAGE_GAP_CYCLES - 1)) begin
            gap_cnt_d          = '0;
            rst_out_d[idx_q]   = 1'b0;
            idx_d              = idx_q + 1'b1;
            if (idx_q == IDX_W'(N_RST_OUT - 1)) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end

        default: begin
          state_d = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  // FSM, counters and registered reset outputs; async reset puts every stage back in reset.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_WAIT_LOCK;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.btn_db    = btn_db_w;
  assign bus.btn_press = btn_press_w;
  assign bus.rst_out   = rst_out_q;
  assign bus.ready     = ready_q;
  assign bus.state_dbg = state_q;

endmodule
